seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL be parametrised as follows (name, default, meaning):
- DW, 8: dividend and quotient width in bits; legal range 2 to 32.
- VW, 7: divisor and remainder width in bits; legal range 2 to DW.
REQ-002 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous active-high reset.
- start, input, 1: request a division; sampled only when busy=0.
- dividendin, input, DW: unsigned dividend.
- divisorin, input, VW: unsigned divisor.
- quotient, output, DW: unsigned result.
- remainder, output, VW: unsigned remainder.
- busy, output, 1: division in progress.
- done, output, 1: one-cycle result-valid pulse.
- dz, output, 1: divide-by-zero flag for the last result.

Function
REQ-004 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-005 When start=1 in IDLE or DONE, the rising edge SHALL:
- capture dividendin into the shift register;
- capture divisorin zero-extended to VW+1 bits;
- clear the partial remainder (VW+1 bits);
- load the iteration counter with DW;
- clear dz and go to CALC.
REQ-006 The exception to REQ-005: if divisorin=0 on that edge, the block SHALL go to DONE instead, setting quotient to all ones, remainder to 0 and dz=1.
REQ-007 Each CALC cycle SHALL perform one restoring step:
- left-shift {partial remainder, quotient register} by 1;
- trial = partial remainder - divisor, computed at VW+2 bits;
- if trial is non-negative, partial remainder takes the trial value and quotient bit 0 = 1; otherwise the partial remainder is kept and bit 0 = 0;
- decrement the counter.
REQ-008 The block SHALL leave CALC for DONE on the edge that performs the DW-th step, so done is high DW cycles after the start edge, or 1 cycle after it in the divide-by-zero case.
REQ-009 done SHALL be high only in DONE, for exactly one cycle; DONE SHALL go to IDLE unless start=1 (see REQ-005).
REQ-010 busy SHALL be 1 exactly in CALC.
REQ-011 In CALC, start, dividendin and divisorin SHALL be ignored.
REQ-012 quotient and remainder SHALL be driven from registers only.
REQ-013 quotient and remainder SHALL hold the last completed result in IDLE and DONE, and SHALL update only on the edge entering DONE; they SHALL NOT show intermediate values during CALC.
REQ-014 remainder SHALL equal the low VW bits of the final partial remainder, which SHALL be less than the divisor.
REQ-015 The result SHALL satisfy dividend = quotient*divisor + remainder for every non-zero divisor.
REQ-016 The block SHALL produce no X or Z on any output after the first reset edge.

Reset
REQ-017 When reset=1 at a rising edge, the block SHALL:
- enter IDLE;
- set quotient=0, remainder=0, busy=0, done=0 and dz=0;
- clear the counter, partial remainder and divisor registers.
REQ-018 reset SHALL take priority over start in every state.
REQ-019 A reset during CALC SHALL abort the division with no done pulse; the next start after reset is released SHALL run normally.

Verification
REQ-020 With DW=8 and VW=7, the bench SHALL cover these directed scenarios:
- dividend 200, divisor 7 -> done 8 cycles after start, quotient=28, remainder=4, dz=0.
- dividend 255, divisor 127 -> quotient=2, remainder=1; dividend 0, divisor 3 -> quotient=0, remainder=0.
- dividend 5, divisor 0 -> done 1 cycle after start, quotient=255, remainder=0, dz=1, busy never high.
- start with 200/7, reset at cycle 4, then 100/9 -> no done for the first request; second request gives quotient=11, remainder=1.
- start pulsed again during CALC with 9/3 -> ignored, result still 28/4; back-to-back start in the DONE cycle is accepted.
REQ-021 With DW=16 and VW=12, the bench SHALL check dividend 65535, divisor 4095 -> done 16 cycles after start, quotient=16, remainder=15.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider -- multi-cycle restoring divider (unsigned).
//
// Computes dividendin / divisorin one quotient bit per clock. A non-zero
// division takes DW CALC cycles. A zero divisor skips CALC and reports
// quotient = all ones, remainder = 0, dz = 1.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high
//   start      : request a division (ignored while busy)
//   dividendin : DW-bit unsigned dividend
//   divisorin  : VW-bit unsigned divisor
//   quotient   : DW-bit result, registered, holds last completed result
//   remainder  : VW-bit result, registered, holds last completed result
//   busy       : high exactly while in CALC
//   done       : one-cycle pulse when a result is presented
//   dz         : last result was a divide-by-zero
module seq_divider #(
   parameter int DW = 8,
   parameter int VW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] dividendin,
   input  logic [VW-1:0] divisorin,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          busy,
   output logic          done,
   output logic          dz
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state_q;
   logic [DW-1:0] shf_q;    // dividend shifting out, quotient shifting in
   logic [VW:0]   prem_q;   // partial remainder
   logic [VW:0]   dvs_q;    // zero-extended divisor
   logic [CW-1:0] cnt_q;    // steps left
   logic [DW-1:0] quot_q;
   logic [VW-1:0] rem_q;
   logic          busy_q;
   logic          done_q;
   logic          dz_q;

   // One restoring step. The partial remainder is always below the divisor,
   // so the shifted value fits VW+1 bits and bit VW+1 of the trial is a
   // clean sign bit.
   logic [VW+1:0] shifted_d;
   logic [VW+1:0] trial_d;
   logic          qbit_d;
   logic [VW:0]   prem_d;
   logic [DW-1:0] shf_d;

   always_comb begin
      shifted_d = {prem_q, shf_q[DW-1]};
      trial_d   = shifted_d - {1'b0, dvs_q};
      qbit_d    = ~trial_d[VW+1];
      prem_d    = qbit_d ? trial_d[VW:0] : shifted_d[VW:0];
      shf_d     = {shf_q[DW-2:0], qbit_d};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shf_q   <= '0;
         prem_q  <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            CALC: begin
               shf_q  <= shf_d;
               prem_q <= prem_d;
               cnt_q  <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  // Final step: publish the result on the same edge.
                  quot_q  <= shf_d;
                  rem_q   <= prem_d[VW-1:0];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin   // IDLE and DONE behave alike
               done_q <= 1'b0;
               if (start) begin
                  if (divisorin == '0) begin
                     quot_q  <= '1;
                     rem_q   <= '0;
                     dz_q    <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     shf_q   <= dividendin;
                     dvs_q   <= {1'b0, divisorin};
                     prem_q  <= '0;
                     cnt_q   <= CW'(DW);
                     dz_q    <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= CALC;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dz        = dz_q;

endmodule
